// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter and its prescaler.
package mod_updown_counter_pkg;

    // Count direction as seen on the 'up' input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Register width needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Counter parameters are consistent: reset value inside the range,
    // modulus at least 2 and representable in the chosen width.
    function automatic bit counter_params_ok(input int width, input int modulus, input int rst_val);
        return (width >= 1) && (width <= 16) &&
               (modulus >= 2) && (modulus <= (2 ** width)) &&
               (rst_val >= 0) && (rst_val < modulus);
    endfunction

    // Prescale ratio lies in the supported range.
    function automatic bit prescale_ok(input int prescale);
        return (prescale >= 1) && (prescale <= 65536);
    endfunction

endpackage

// File: rtl/mod_updown_counter_en_prescaler.sv
// Clock-enable divider: tick_o fires on every PRESCALE-th enabled cycle.
// The phase holds while en_i is low and restarts from zero on clr_i.
module en_prescaler
    import mod_updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            PW   = cnt_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_reg;

    if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
        $error("en_prescaler: PRESCALE=%0d outside 1..65536", PRESCALE);
    end

    // With PRESCALE==1, LAST is 0 so the phase stays at 0 and tick_o follows en_i.
    assign tick_o = en_i && (cnt_reg == LAST);

    // Phase counter: cleared by reset/clr, advances only on enabled cycles, wraps on tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (en_i) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clear, parallel load, prescaled enable,
// terminal-count output and registered wrap / illegal-load strobes.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] Q,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             wrap_reg, wrap_next;
    logic             err_reg, err_next;
    logic             tick;
    logic             pre_clr;
    dir_e             dir;

    if (!counter_params_ok(WIDTH, MODULUS, RST_VAL)) begin : g_bad_params
        $error("mod_updown_counter: illegal WIDTH=%0d MODULUS=%0d RST_VAL=%0d",
               WIDTH, MODULUS, RST_VAL);
    end

    // A load restarts the prescale period just like a clear does.
    assign pre_clr = clr | load;
    assign dir     = dir_e'(up);

    en_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (pre_clr),
        .en_i   (en),
        .tick_o (tick)
    );

    // Next-state: clr beats load beats count; out-of-range loads saturate to MODULUS-1.
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (clr) begin
            q_next = RST_Q;
        end else if (load) begin
            if ({1'b0, din} >= MOD_EXT) begin
                q_next   = Q_MAX;
                err_next = 1'b1;
            end else begin
                q_next = din;
            end
        end else if (tick) begin
            if (dir == DIR_UP) begin
                if (q_reg == Q_MAX) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_reg + 1'b1;
                end
            end else begin
                if (q_reg == '0) begin
                    q_next    = Q_MAX;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_reg - 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_reg    <= RST_Q;
            wrap_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
            err_reg  <= err_next;
        end
    end

    // Terminal count is combinational so a cascade can look ahead without latency.
    assign tc_o     = en && ((dir == DIR_UP) ? (q_reg == Q_MAX) : (q_reg == '0));
    assign Q        = q_reg;
    assign wrap_o   = wrap_reg;
    assign load_err = err_reg;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: reset, wrap in both directions,
// loads, prescaler phase retention and a two-digit decimal cascade.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // DUT A: W=4, M=10, P=1, RST_VAL=3
    logic       a_reset, a_clr, a_load, a_en, a_up;
    logic [3:0] a_din, a_q;
    logic       a_tc, a_wrap, a_err;

    // DUT P: W=4, M=10, P=3, RST_VAL=0
    logic       p_reset, p_clr, p_load, p_en, p_up;
    logic [3:0] p_din, p_q;
    logic       p_tc, p_wrap, p_err;

    // Cascade: two W=4, M=10 stages, stage1.en = stage0.wrap_o
    logic       c_reset;
    logic [3:0] c_q0, c_q1;
    logic       c_tc0, c_tc1, c_wrap0, c_wrap1, c_err0, c_err1;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .RST_VAL(3)) dut_a (
        .clk(clk), .reset(a_reset), .clr(a_clr), .load(a_load), .din(a_din),
        .en(a_en), .up(a_up), .Q(a_q), .tc_o(a_tc), .wrap_o(a_wrap), .load_err(a_err)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .RST_VAL(0)) dut_p (
        .clk(clk), .reset(p_reset), .clr(p_clr), .load(p_load), .din(p_din),
        .en(p_en), .up(p_up), .Q(p_q), .tc_o(p_tc), .wrap_o(p_wrap), .load_err(p_err)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .RST_VAL(0)) dut_c0 (
        .clk(clk), .reset(c_reset), .clr(1'b0), .load(1'b0), .din(4'd0),
        .en(1'b1), .up(1'b1), .Q(c_q0), .tc_o(c_tc0), .wrap_o(c_wrap0), .load_err(c_err0)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .RST_VAL(0)) dut_c1 (
        .clk(clk), .reset(c_reset), .clr(1'b0), .load(1'b0), .din(4'd0),
        .en(c_wrap0), .up(1'b1), .Q(c_q1), .tc_o(c_tc1), .wrap_o(c_wrap1), .load_err(c_err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset = 1'b0; a_clr = 1'b0; a_load = 1'b0; a_din = 4'd0; a_en = 1'b0; a_up = 1'b1;
        p_reset = 1'b0; p_clr = 1'b0; p_load = 1'b0; p_din = 4'd0; p_en = 1'b0; p_up = 1'b1;
        c_reset = 1'b0;

        // T1: reset held two cycles
        step();
        step();
        check("T1 reset Q", a_q, 3);
        check("T1 reset wrap", a_wrap, 0);
        check("T1 reset err", a_err, 0);
        check("T1 reset tc", a_tc, 0);
        a_reset = 1'b1;
        step();
        check("T1 hold Q", a_q, 3);

        // T2: up count 0..9,0 with wrap and terminal count
        a_load = 1'b1; a_din = 4'd0;
        step();
        check("T2 load0 Q", a_q, 0);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            $display("T2 step %0d: Q=%0d tc=%0d wrap=%0d", i, a_q, a_tc, a_wrap);
            check("T2 up Q", a_q, i % 10);
            check("T2 up wrap", a_wrap, (i == 10) ? 1 : 0);
            check("T2 up tc", a_tc, ((i % 10) == 9) ? 1 : 0);
        end

        // T3: down count from 1 through 0 to 9, 8
        a_up = 1'b0;
        step();
        check("T3 down Q0", a_q, 0);
        check("T3 down tc0", a_tc, 1);
        check("T3 down wrap0", a_wrap, 0);
        step();
        check("T3 down Q9", a_q, 9);
        check("T3 down wrap9", a_wrap, 1);
        check("T3 down tc9", a_tc, 0);
        step();
        check("T3 down Q8", a_q, 8);
        check("T3 down wrap8", a_wrap, 0);

        // T4: legal load, illegal load, clr priority
        a_en = 1'b0; a_load = 1'b1; a_din = 4'd7;
        step();
        check("T4 load7 Q", a_q, 7);
        check("T4 load7 err", a_err, 0);
        a_din = 4'd12;
        step();
        check("T4 load12 Q", a_q, 9);
        check("T4 load12 err", a_err, 1);
        a_load = 1'b0; a_up = 1'b1;
        step();
        check("T4 after Q", a_q, 9);
        check("T4 err pulse end", a_err, 0);
        check("T4 tc en0", a_tc, 0);
        a_en = 1'b1;
        #1;
        check("T4 tc en1", a_tc, 1);
        a_clr = 1'b1;
        step();
        check("T4 clr Q", a_q, 3);
        check("T4 clr wrap", a_wrap, 0);
        a_load = 1'b1; a_din = 4'd12;
        step();
        check("T4 clr+load Q", a_q, 3);
        check("T4 clr+load err", a_err, 0);
        a_clr = 1'b0; a_load = 1'b0;
        step();
        check("T4 resume Q", a_q, 4);
        a_en = 1'b0;

        // T5: prescale by 3 with en dropped mid-period
        step();
        check("T5 reset Q", p_q, 0);
        p_reset = 1'b1; p_en = 1'b1; p_up = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("T5 presc Q", p_q, i / 3);
        end
        p_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("T5 en-off Q", p_q, 1);
        end
        p_en = 1'b1;
        step();
        check("T5 phase kept Q", p_q, 2);
        p_load = 1'b1; p_din = 4'd4;
        step();
        check("T5 load Q", p_q, 4);
        p_load = 1'b0;
        step();
        check("T5 post-load 1", p_q, 4);
        step();
        check("T5 post-load 2", p_q, 4);
        step();
        check("T5 post-load 3", p_q, 5);

        // T6: decimal cascade 00..99..00, then reset at 57
        step();
        check("T6 reset", {c_q1, c_q0}, 0);
        c_reset = 1'b1;
        for (int n = 1; n <= 105; n++) begin
            step();
            check("T6 count", {c_q1, c_q0}, 32'((((n - 1) / 10) % 10) * 16 + (n % 10)));
        end
        c_reset = 1'b0;
        step();
        check("T6 reset2", {c_q1, c_q0}, 0);
        c_reset = 1'b1;
        for (int n = 1; n <= 57; n++) begin
            step();
        end
        check("T6 at 57", {c_q1, c_q0}, 32'h57);
        c_reset = 1'b0;
        step();
        check("T6 mid reset Q", {c_q1, c_q0}, 0);
        check("T6 mid reset wrap", {c_wrap1, c_wrap0}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
